pwm_deadtime_driver: RTL



---
 rtl/pwm_drv_pkg.sv | 21 ++
 rtl/pwm_deadtime_driver_sync_2ff.sv | 27 ++
 rtl/pwm_deadtime_driver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pwm_drv_pkg.sv
// Shared types and constants for the complementary PWM gate driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_drv_pkg;

    localparam int DT_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;

    // Glitch counter stops here instead of wrapping.
    localparam logic [7:0] GLITCH_SAT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DT_TO_LO = 3'd1,
        LO_ON    = 3'd2,
        DT_TO_HI = 3'd3,
        HI_ON    = 3'd4,
        FAULT    = 3'd5
    } state_t;

endpackage

// File: rtl/pwm_deadtime_driver_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Latency: input change is visible on q_o after 2 clk edges.
// Backpressure: none; free-running level path.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwm_deadtime_driver.sv
// Splits a single-ended PWM into non-overlapping high/low gate drives with a
// programmable dead gap, latched fault shutdown and event counters.
// Latency: gate change 1 edge after pwm_in; opposite gate after dead_cycles+1 more. No backpressure.
module pwm_deadtime_driver
    import pwm_drv_pkg::*;
#(
    parameter int DT_W  = DT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pwm_in,
    input  logic [DT_W-1:0]  dead_cycles,
    input  logic             fault_in,
    input  logic             fault_clr,
    output logic             out_hi,
    output logic             out_lo,
    output logic             busy,
    output logic             fault_latched,
    output logic [CNT_W-1:0] hi_pulse_count,
    output logic [7:0]       glitch_count
);

    state_t            state_q, state_d;
    logic [DT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
    logic [7:0]        gl_cnt_q, gl_cnt_d;
    logic              fault_s;

    sync_2ff u_fault_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (fault_in),
        .q_o   (fault_s)
    );

    // State, dead-time counter and event counters; async reset drops the gates at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_cnt_q <= '0;
            gl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_cnt_q <= hi_cnt_d;
            gl_cnt_q <= gl_cnt_d;
        end
    end

    // Next state: fault wins, then enable, then the normal PWM-following transitions.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_cnt_d = hi_cnt_q;
        gl_cnt_d = gl_cnt_q;

        if (fault_s) begin
            state_d = FAULT;
        end else if (!enable && state_q != FAULT) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = pwm_in ? DT_TO_HI : DT_TO_LO;
                    cnt_d   = dead_cycles;
                end
                DT_TO_HI: begin
                    if (!pwm_in) begin
                        // Target flipped mid-gap: restart the gap towards the other side.
                        state_d = DT_TO_LO;
                        cnt_d   = dead_cycles;
                        if (gl_cnt_q != GLITCH_SAT) gl_cnt_d = gl_cnt_q + 8'd1;
                    end else if (cnt_q == '0) begin
                        state_d  = HI_ON;
                        hi_cnt_d = hi_cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                DT_TO_LO: begin
                    if (pwm_in) begin
                        state_d = DT_TO_HI;
                        cnt_d   = dead_cycles;
                        if (gl_cnt_q != GLITCH_SAT) gl_cnt_d = gl_cnt_q + 8'd1;
                    end else if (cnt_q == '0) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - DT_W'(1);
                    end
                end
                HI_ON: begin
                    if (!pwm_in) begin
                        state_d = DT_TO_LO;
                        cnt_d   = dead_cycles;
                    end
                end
                LO_ON: begin
                    if (pwm_in) begin
                        state_d = DT_TO_HI;
                        cnt_d   = dead_cycles;
                    end
                end
                FAULT: begin
                    // fault_s is known low here; a clear only counts once the fault is gone.
                    if (fault_clr) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Moore outputs straight off the state register so both gates can never overlap.
    assign out_hi         = (state_q == HI_ON);
    assign out_lo         = (state_q == LO_ON);
    assign busy           = (state_q == DT_TO_HI) || (state_q == DT_TO_LO);
    assign fault_latched  = (state_q == FAULT);
    assign hi_pulse_count = hi_cnt_q;
    assign glitch_count   = gl_cnt_q;

endmodule
